// File: rtl/mux_serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial mux stage.
package mux_serializer_pkg;

    // state | meaning
    // IDLE  | no word held, ready for a new word
    // SHIFT | word held, one bit presented per accepted beat
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Select counter width: clog2 of the word width, never narrower than one bit.
    function automatic int calc_idx_w(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/mux_n_to_1.sv
// Parameterised WIDTH:1 bit mux; a select value beyond the last input gives 0.
module mux_n_to_1 #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic [WIDTH-1:0] d,
    input  logic [IDX_W-1:0] sel,
    output logic             y
);

    // Compare against every legal index so an out-of-range select falls through to 0.
    always_comb begin
        y = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sel == IDX_W'(i)) begin
                y = d[i];
            end
        end
    end

endmodule

// File: rtl/mux_serializer.sv
// Parallel-to-serial stage: captures a word (optionally inverted) and emits it LSB first.
//
// state | meaning
// IDLE  | nothing held; up_ready=1, down_valid=0
// SHIFT | word held; word[idx] on down_data, idx advances on each accepted beat
module mux_serializer
    import mux_serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_invert,
    output logic             down_valid,
    input  logic             down_ready,
    output logic             down_data,
    output logic             down_last,
    output logic             busy
);

    localparam int IDX_W = calc_idx_w(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [WIDTH-1:0] word, word_next;
    logic             mux_bit;
    logic             capture;
    logic             beat;

    mux_n_to_1 #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_bit_mux (
        .d   (word),
        .sel (idx),
        .y   (mux_bit)
    );

    // Outputs decode straight from registers; up_ready is the only path from an input.
    always_comb begin
        down_valid = (state == SHIFT);
        busy       = (state == SHIFT);
        down_last  = (state == SHIFT) && (idx == LAST_IDX);
        down_data  = (state == SHIFT) && mux_bit;
        up_ready   = (state == IDLE) || (down_last && down_ready);
    end

    // Next state, select counter and held word; a last beat with a waiting word reloads in place.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        word_next  = word;
        capture    = up_valid && up_ready;
        beat       = down_valid && down_ready;
        case (state)
            IDLE: begin
                if (capture) begin
                    word_next  = up_invert ? ~up_data : up_data;
                    idx_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (beat) begin
                    if (!down_last) begin
                        idx_next = idx + IDX_W'(1);
                    end else if (capture) begin
                        word_next  = up_invert ? ~up_data : up_data;
                        idx_next   = '0;
                        state_next = SHIFT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Register update; reset discards any partially sent word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            word  <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            word  <= word_next;
        end
    end

endmodule

// File: tb/tb_mux_serializer.sv
// Bench for mux_serializer: table vectors, corner sequences and a random run against a bit-queue model.
module tb_mux_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       up_valid, up_invert, down_ready;
    logic [7:0] up_data;
    logic       up_ready, down_valid, down_data, down_last, busy;

    logic       w1_up_valid, w1_up_invert, w1_down_ready;
    logic [0:0] w1_up_data;
    logic       w1_up_ready, w1_down_valid, w1_down_data, w1_down_last, w1_busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic b;
        logic last;
    } bit_t;
    bit_t q[$];

    logic [7:0] got;
    int         got_n;
    logic       seen_dv, seen_ur;

    typedef struct {
        logic [7:0] data;
        logic       inv;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[7];

    mux_serializer #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_invert  (up_invert),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data),
        .down_last  (down_last),
        .busy       (busy)
    );

    mux_serializer #(.WIDTH(1)) dut_w1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (w1_up_valid),
        .up_ready   (w1_up_ready),
        .up_data    (w1_up_data),
        .up_invert  (w1_up_invert),
        .down_valid (w1_down_valid),
        .down_ready (w1_down_ready),
        .down_data  (w1_down_data),
        .down_last  (w1_down_last),
        .busy       (w1_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the 8-bit instance: drive, compare against the model queue, then advance it.
    task automatic step(input logic v, input logic [7:0] d, input logic inv, input logic rdy);
        logic       exp_ready;
        logic [7:0] w;
        @(negedge clk);
        up_valid   = v;
        up_data    = d;
        up_invert  = inv;
        down_ready = rdy;
        #1;
        chk("down_valid", down_valid, q.size() > 0);
        chk("busy", busy, q.size() > 0);
        if (q.size() > 0) begin
            chk("down_data", down_data, q[0].b);
            chk("down_last", down_last, q[0].last);
        end
        exp_ready = (q.size() == 0) || (q.size() == 1 && rdy);
        chk("up_ready", up_ready, exp_ready);
        seen_dv = down_valid;
        seen_ur = up_ready;
        if (q.size() > 0 && rdy) begin
            got = {down_data, got[7:1]};
            got_n++;
            void'(q.pop_front());
        end
        if (v && exp_ready) begin
            w = inv ? ~d : d;
            for (int i = 0; i < 8; i++) q.push_back('{b: w[i], last: (i == 7)});
        end
    endtask

    // Send one word with down_ready held high and check it drains in exactly eight cycles.
    task automatic send_word(input string name, input logic [7:0] d, input logic inv, input logic [7:0] exp);
        int n;
        got   = '0;
        got_n = 0;
        step(1'b1, d, inv, 1'b1);
        n = 0;
        while (q.size() > 0 && n < 40) begin
            step(1'b0, 8'($urandom), 1'($urandom), 1'b1);
            n++;
        end
        chk({name, "_cycles"}, n, 8);
        chk({name, "_word"}, got, exp);
        chk({name, "_beats"}, got_n, 8);
    endtask

    initial begin
        int n;
        int ur_cnt;
        int dv_cnt;
        logic [2:0] w1_words;
        logic [3:0] bp_pat;

        rst_n = 1'b0;
        up_valid = 1'b0; up_data = '0; up_invert = 1'b0; down_ready = 1'b1;
        w1_up_valid = 1'b0; w1_up_data = '0; w1_up_invert = 1'b0; w1_down_ready = 1'b1;
        got = '0; got_n = 0;

        // Reset values
        #3;
        chk("rst_down_valid", down_valid, 1'b0);
        chk("rst_down_last", down_last, 1'b0);
        chk("rst_down_data", down_data, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_up_ready", up_ready, 1'b1);
        chk("rst_w1_down_valid", w1_down_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single words
        vecs[0] = '{data: 8'hA5, inv: 1'b0, exp: 8'hA5};
        vecs[1] = '{data: 8'h0F, inv: 1'b1, exp: 8'hF0};
        vecs[2] = '{data: 8'h3C, inv: 1'b0, exp: 8'h3C};
        vecs[3] = '{data: 8'hFF, inv: 1'b0, exp: 8'hFF};
        vecs[4] = '{data: 8'h00, inv: 1'b1, exp: 8'hFF};
        vecs[5] = '{data: 8'h01, inv: 1'b0, exp: 8'h01};
        vecs[6] = '{data: 8'h80, inv: 1'b1, exp: 8'h7F};
        for (int i = 0; i < 7; i++) begin
            send_word("tbl", vecs[i].data, vecs[i].inv, vecs[i].exp);
            step(1'b0, 8'h00, 1'b0, 1'b1);
        end

        // Backpressure with ready pattern 1,0,0,1 repeating
        bp_pat = 4'b1001;
        got = '0; got_n = 0;
        step(1'b1, 8'h3C, 1'b0, 1'b1);
        n = 0;
        while (q.size() > 0 && n < 100) begin
            step(1'b0, 8'($urandom), 1'b0, bp_pat[n % 4]);
            n++;
        end
        chk("bp_drained", q.size(), 0);
        chk("bp_word", got, 8'h3C);
        chk("bp_beats", got_n, 8);

        // Back-to-back: FF then 00 with up_valid held, no bubble
        got = '0; got_n = 0;
        step(1'b1, 8'hFF, 1'b0, 1'b1);
        ur_cnt = 0;
        dv_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            step(k < 8, 8'h00, 1'b0, 1'b1);
            if (seen_dv) dv_cnt++;
            if (k < 8 && seen_ur) ur_cnt++;
            if (k == 7) chk("b2b_ready_on_last", seen_ur, 1'b1);
        end
        chk("b2b_valid_beats", dv_cnt, 16);
        chk("b2b_ready_pulses", ur_cnt, 1);
        chk("b2b_second_word", got, 8'h00);
        chk("b2b_beats", got_n, 16);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset after three bits of AA
        step(1'b1, 8'hAA, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_down_valid", down_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_down_data", down_data, 1'b0);
        chk("arst_down_last", down_last, 1'b0);
        chk("arst_up_ready", up_ready, 1'b1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send_word("post_rst", 8'h01, 1'b0, 8'h01);

        // Random traffic against the queue model
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
        end
        n = 0;
        while (q.size() > 0 && n < 40) begin
            step(1'b0, 8'($urandom), 1'b0, 1'b1);
            n++;
        end
        chk("rand_drained", q.size(), 0);

        // WIDTH=1 instance: stream 1,0,1 with up_valid held
        w1_words = 3'b101;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            w1_up_valid   = (i < 3);
            w1_up_data    = (i < 3) ? w1_words[2 - i] : 1'b0;
            w1_up_invert  = 1'b0;
            w1_down_ready = 1'b1;
            #1;
            if (i == 0) begin
                chk("w1_idle_valid", w1_down_valid, 1'b0);
            end else begin
                chk("w1_valid", w1_down_valid, 1'b1);
                chk("w1_data", w1_down_data, w1_words[3 - i]);
                chk("w1_last", w1_down_last, 1'b1);
            end
            chk("w1_up_ready", w1_up_ready, 1'b1);
        end
        @(negedge clk);
        w1_up_valid = 1'b0;
        #1;
        chk("w1_back_idle", w1_down_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_serializer.md
Name: mux_serializer

Overview:
- Parallel-to-serial stage that sits directly downstream of the 2:1 mux / inverter primitives.
- Accepts a WIDTH-bit word over a valid/ready handshake, optionally inverts it on capture, and emits it one bit per accepted beat, LSB first.
- Bit selection is a WIDTH:1 mux driven by a registered select counter.
- Feeds single-bit consumers (serial links, bit-level testers).

Parameters:
- WIDTH, 8, bits per word; legal range 1..64.
- IDX_W, $clog2(WIDTH) (minimum 1), width of the select counter; derived, never overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- up_valid  input  1  upstream word valid.
- up_ready  output  1  block can accept a word this cycle.
- up_data  input  WIDTH  parallel word.
- up_invert  input  1  sampled with up_data; 1 = store bitwise NOT of up_data.
- down_valid  output  1  serial bit valid.
- down_ready  input  1  downstream accepts the bit.
- down_data  output  1  current serial bit.
- down_last  output  1  current bit is bit WIDTH-1 of the word.
- busy  output  1  a word is held (state SHIFT).

Behaviour:
- Interface: one clock domain; reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous):
  - state=IDLE, idx=0, word=0.
  - down_valid=0, down_last=0, down_data=0, busy=0.
  - up_ready=1 once rst_n is deasserted.
- States: IDLE, SHIFT.
- IDLE:
  - up_ready=1, down_valid=0.
  - On up_valid&&up_ready: word <= up_invert ? ~up_data : up_data; idx <= 0; go to SHIFT.
- SHIFT outputs:
  - down_valid=1, busy=1.
  - down_data=word[idx], driven combinationally from registers via the WIDTH:1 mux.
  - down_last=(idx==WIDTH-1).
- SHIFT, beat accepted (down_valid&&down_ready):
  - If !down_last: idx <= idx+1.
  - If down_last and up_valid: capture the new word and stay in SHIFT with idx <= 0. This gives zero-bubble back-to-back words.
  - If down_last and !up_valid: go to IDLE.
- up_ready in SHIFT = down_last && down_ready. This is the only combinational input-to-output path.
- Backpressure: while down_valid && !down_ready, down_data, down_last and idx are held stable. No bit is dropped or repeated.
- Latency:
  - First bit is valid the cycle after the word is accepted.
  - A word occupies exactly WIDTH accepted beats.
  - Sustained throughput is 1 bit/cycle with down_ready=1.
- WIDTH=1: down_last=1 on every beat; idx is constant 0 (IDX_W=1, never incremented).
- idx never exceeds WIDTH-1. No wrap occurs except via the explicit reset to 0 on word capture.
- up_data and up_invert are don't-care when not captured. up_invert affects only the word being captured.
- Reset mid-word: the partial word is discarded. Outputs drop asynchronously to their reset values, and no further bits of that word are emitted.
- X-safety: up_data is never sampled unless up_valid&&up_ready.

Decomposition:
- Package mux_serializer_pkg:
  - state_t enum {IDLE, SHIFT}.
  - Function for IDX_W (clog2 with minimum 1).
- Sub-module mux_n_to_1:
  - Parameterised WIDTH:1 bit mux (inputs d[WIDTH-1:0], sel[IDX_W-1:0], output y).
  - Instantiated once for down_data.
  - Out-of-range sel yields 0.
- The inversion is a plain bitwise NOT at capture. No separate module.

Test Plan:
- Reset then single word:
  - Stimulus: WIDTH=8, up_data=8'hA5, up_invert=0, down_ready=1.
  - Response: down_data sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles; down_last only on the 8th; return to IDLE with up_ready=1.
- Inversion:
  - Stimulus: up_data=8'h0F, up_invert=1.
  - Response: bits 0,0,0,0,1,1,1,1; down_last on the 8th.
- Backpressure:
  - Stimulus: 8'h3C with down_ready toggled 1,0,0,1,...
  - Response: down_data/idx held during low cycles; exactly 8 accepted beats carrying 0,0,1,1,1,1,0,0.
- Back-to-back:
  - Stimulus: up_valid held high with 8'hFF then 8'h00, down_ready=1.
  - Response: 16 contiguous valid beats (eight 1s then eight 0s); up_ready pulses exactly on the cycle of the first word's last beat; no bubble.
- Async reset mid-word:
  - Stimulus: assert rst_n=0 after 3 bits of 8'hAA.
  - Response: down_valid falls without a clock edge; after release, up_ready=1, and a new word 8'h01 emits 1,0,0,0,0,0,0,0 from idx 0.
- Edge WIDTH=1:
  - Stimulus: stream words 1,0,1.
  - Response: each word gives one beat with down_last=1; output 1,0,1 in 3 cycles.
